// File: rtl/if_pkg.sv
// -----------------------------------------------------------------------------
// if_pkg
// Shared definitions for the instruction-fetch prefetch stage.
//   XLEN_DEFAULT : default address/instruction width
//   NOP          : canonical RV32 no-op (addi x0, x0, 0)
//   if_entry_t   : prefetch queue entry layout {pc, instr} at the default width
//   count_width  : bits needed to hold an occupancy count of 0..depth
// -----------------------------------------------------------------------------
package if_pkg;

   localparam int unsigned XLEN_DEFAULT = 32;

   localparam logic [31:0] NOP = 32'h0000_0013;

   // Queue entry: PC in the upper half, instruction in the lower half.
   typedef struct packed {
      logic [XLEN_DEFAULT-1:0] pc;
      logic [XLEN_DEFAULT-1:0] instr;
   } if_entry_t;

   // An occupancy of exactly 'depth' must be representable, hence the +1.
   function automatic int unsigned count_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// -----------------------------------------------------------------------------
// if_fetch_fifo
// Synchronous FIFO used as the prefetch queue. DEPTH must be a power of two so
// the read/write pointers wrap naturally. Flush has priority over push and pop.
// A push into a full FIFO is ignored (the surrounding credit logic never does
// it). The head word is presented combinationally from the storage registers.
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   flush          : empty the FIFO this cycle
//   push, wdata    : write request and data
//   pop            : remove the head entry
//   rdata          : head entry (stale when empty)
//   full, empty    : occupancy flags
//   count          : number of occupied entries
// -----------------------------------------------------------------------------
module if_fetch_fifo
   import if_pkg::*;
#(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 4
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             flush,
   input  logic                             push,
   input  logic [WIDTH-1:0]                 wdata,
   input  logic                             pop,
   output logic [WIDTH-1:0]                 rdata,
   output logic                             full,
   output logic                             empty,
   output logic [count_width(DEPTH)-1:0]    count
);

   localparam int unsigned CW = count_width(DEPTH);
   localparam int unsigned AW = $clog2(DEPTH);

   localparam logic [AW-1:0] PTR_ZERO = AW'(1'b0);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign full      = (count_q == CNT_FULL);
   assign empty     = (count_q == CNT_ZERO);
   assign count     = count_q;
   assign rdata     = mem_q[rd_ptr_q];
   assign push_ok_s = push & ~full;
   assign pop_ok_s  = pop & ~empty;

   // Next-state for storage, pointers and occupancy
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = PTR_ZERO;
         rd_ptr_d = PTR_ZERO;
         count_d  = CNT_ZERO;
      end else begin
         if (push_ok_s) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         count_d = count_q + (push_ok_s ? CNT_ONE : CNT_ZERO)
                           - (pop_ok_s  ? CNT_ONE : CNT_ZERO);
      end
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= PTR_ZERO;
         rd_ptr_q <= PTR_ZERO;
         count_q  <= CNT_ZERO;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are only meaningful between the pointers
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/if_prefetch_stage_chk.sv
// -----------------------------------------------------------------------------
// if_prefetch_stage_chk
// Simulation-time invariants of the prefetch stage credit scheme.
// Ports:
//   clk, rst_n : clock and synchronous active-low reset
//   push       : a response is being written into the queue
//   full       : queue is full
//   in_use     : outstanding requests plus queued entries
// -----------------------------------------------------------------------------
module if_prefetch_stage_chk #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CW    = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          full,
   input  logic [CW:0]   in_use
);

   localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);

   // Credits must make a push into a full queue impossible.
   a_no_push_when_full: assert property (
      @(posedge clk) disable iff (!rst_n) push |-> !full
   );

   // Requests in flight plus buffered entries never exceed the queue size.
   a_credit_bound: assert property (
      @(posedge clk) disable iff (!rst_n) in_use <= LIMIT
   );

endmodule

// File: rtl/if_prefetch_stage.sv
// -----------------------------------------------------------------------------
// if_prefetch_stage
// Credit-limited instruction prefetch stage. Issues in-order word requests to a
// variable-latency instruction memory, buffers up to QUEUE_DEPTH responses and
// hands them to decode over valid/ready. A redirect flushes the queue, restarts
// fetch at the (word-aligned) redirect PC and drops every response still in
// flight.
// Ports:
//   clk, rst_n                       : clock, synchronous active-low reset
//   redirect_valid, redirect_pc      : flush and restart request from EX
//   imem_req, imem_addr, imem_gnt    : request channel (req is combinational)
//   imem_rvalid, imem_rdata          : in-order response channel
//   id_valid, id_ready               : decode handshake
//   id_pc, id_pc_plus4, id_instr     : head entry (all zero when queue empty)
//   queue_count                      : occupied queue entries
// -----------------------------------------------------------------------------
module if_prefetch_stage
   import if_pkg::*;
#(
   parameter int unsigned     XLEN        = XLEN_DEFAULT,
   parameter logic [XLEN-1:0] RESET_PC    = {XLEN{1'b0}},
   parameter int unsigned     QUEUE_DEPTH = 4
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  redirect_valid,
   input  logic [XLEN-1:0]                       redirect_pc,
   output logic                                  imem_req,
   output logic [XLEN-1:0]                       imem_addr,
   input  logic                                  imem_gnt,
   input  logic                                  imem_rvalid,
   input  logic [XLEN-1:0]                       imem_rdata,
   output logic                                  id_valid,
   input  logic                                  id_ready,
   output logic [XLEN-1:0]                       id_pc,
   output logic [XLEN-1:0]                       id_pc_plus4,
   output logic [XLEN-1:0]                       id_instr,
   output logic [count_width(QUEUE_DEPTH)-1:0]   queue_count
);

   localparam int unsigned     CW           = count_width(QUEUE_DEPTH);
   localparam int unsigned     EW           = 2 * XLEN;
   localparam logic [XLEN-1:0] PC_STEP      = XLEN'(32'd4);
   localparam logic [XLEN-1:0] PC_ZERO      = {XLEN{1'b0}};
   localparam logic [CW-1:0]   CNT_ZERO     = CW'(1'b0);
   localparam logic [CW-1:0]   CNT_ONE      = CW'(1'b1);
   localparam logic [CW:0]     CREDIT_LIMIT = (CW + 1)'(QUEUE_DEPTH);

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] resp_pc_q, resp_pc_d;
   logic [CW-1:0]   outstanding_q, outstanding_d;
   logic [CW-1:0]   discard_q, discard_d;

   logic [XLEN-1:0] redirect_pc_s;
   logic [CW:0]     in_use_s;
   logic            credit_ok_s;
   logic            req_fire_s;
   logic            drop_s;
   logic            push_s;
   logic            pop_s;
   logic [EW-1:0]   fifo_wdata_s;
   logic [EW-1:0]   fifo_rdata_s;
   logic            fifo_full_s;
   logic            fifo_empty_s;
   logic [CW-1:0]   fifo_count_s;
   logic [XLEN-1:0] head_pc_s;
   logic [XLEN-1:0] head_instr_s;

   // Low address bits are meaningless for word fetch.
   assign redirect_pc_s = {redirect_pc[XLEN-1:2], 2'b00};

   // Every granted request reserves a queue slot until its response is popped
   // or dropped, so a response can never find the queue full.
   assign in_use_s    = {1'b0, outstanding_q} + {1'b0, fifo_count_s};
   assign credit_ok_s = (in_use_s < CREDIT_LIMIT);
   assign imem_req    = rst_n & ~redirect_valid & credit_ok_s;
   assign imem_addr   = fetch_pc_q;
   assign req_fire_s  = imem_req & imem_gnt;

   // Responses belonging to a flushed stream are counted off by discard_q.
   assign drop_s = imem_rvalid & (discard_q != CNT_ZERO);
   assign push_s = imem_rvalid & ~redirect_valid & (discard_q == CNT_ZERO);
   assign pop_s  = id_valid & id_ready;

   assign fifo_wdata_s = {resp_pc_q, imem_rdata};
   assign head_pc_s    = fifo_rdata_s[EW-1:XLEN];
   assign head_instr_s = fifo_rdata_s[XLEN-1:0];

   assign id_valid    = ~fifo_empty_s;
   assign id_pc       = fifo_empty_s ? PC_ZERO : head_pc_s;
   assign id_pc_plus4 = fifo_empty_s ? PC_ZERO : head_pc_s + PC_STEP;
   assign id_instr    = fifo_empty_s ? PC_ZERO : head_instr_s;
   assign queue_count = fifo_count_s;

   // Next fetch/response PCs, in-flight count and discard count
   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      resp_pc_d     = resp_pc_q;
      outstanding_d = outstanding_q + (req_fire_s  ? CNT_ONE : CNT_ZERO)
                                    - (imem_rvalid ? CNT_ONE : CNT_ZERO);
      discard_d     = discard_q;
      if (redirect_valid) begin
         fetch_pc_d = redirect_pc_s;
         resp_pc_d  = redirect_pc_s;
         // Everything still in flight after this edge is stale; this also
         // covers any discard left over from an earlier redirect.
         discard_d  = outstanding_q - (imem_rvalid ? CNT_ONE : CNT_ZERO);
      end else begin
         if (req_fire_s) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
         end else begin
            fetch_pc_d = fetch_pc_q;
         end
         if (push_s) begin
            resp_pc_d = resp_pc_q + PC_STEP;
         end else begin
            resp_pc_d = resp_pc_q;
         end
         if (drop_s) begin
            discard_d = discard_q - CNT_ONE;
         end else begin
            discard_d = discard_q;
         end
      end
   end

   // Fetch engine state registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_pc_q    <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         outstanding_q <= CNT_ZERO;
         discard_q     <= CNT_ZERO;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         resp_pc_q     <= resp_pc_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
      end
   end

   if_fetch_fifo #(
      .WIDTH (EW),
      .DEPTH (QUEUE_DEPTH)
   ) u_queue (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (redirect_valid),
      .push  (push_s),
      .wdata (fifo_wdata_s),
      .pop   (pop_s),
      .rdata (fifo_rdata_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s),
      .count (fifo_count_s)
   );

   if_prefetch_stage_chk #(
      .DEPTH (QUEUE_DEPTH),
      .CW    (CW)
   ) u_chk (
      .clk    (clk),
      .rst_n  (rst_n),
      .push   (push_s),
      .full   (fifo_full_s),
      .in_use (in_use_s)
   );

endmodule

// File: tb/tb_if_prefetch_stage.sv
// -----------------------------------------------------------------------------
// tb_if_prefetch_stage
// Directed bench for if_prefetch_stage (RESET_PC=0x100, QUEUE_DEPTH=4). A small
// in-order memory responder grants every request and answers after 'lat'
// cycles with instruction = ~address. Cycle 0 is the first cycle with rst_n
// high; inputs change 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_if_prefetch_stage;

   logic        clk;
   logic        rst_n;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_pc;
   logic [31:0] id_pc_plus4;
   logic [31:0] id_instr;
   logic [2:0]  queue_count;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int lat    = 1;
   logic [31:0] pend_addr [$];
   int          pend_due  [$];

   if_prefetch_stage #(
      .XLEN        (32),
      .RESET_PC    (32'h0000_0100),
      .QUEUE_DEPTH (4)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_pc          (id_pc),
      .id_pc_plus4    (id_pc_plus4),
      .id_instr       (id_instr),
      .queue_count    (queue_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One clock cycle: record a grant mid-cycle, then present the response due
   // in the new cycle.
   task automatic tick();
      @(negedge clk);
      if (rst_n && imem_req && imem_gnt) begin
         pend_addr.push_back(imem_addr);
         pend_due.push_back(cyc + lat);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
         pend_addr.delete();
         pend_due.delete();
      end
      if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
         imem_rvalid = 1'b1;
         imem_rdata  = ~pend_addr[0];
         void'(pend_addr.pop_front());
         void'(pend_due.pop_front());
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = 32'h0;
      end
   endtask

   task automatic do_reset();
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      id_ready       = 1'b0;
      repeat (2) tick();
   endtask

   task automatic release_reset();
      rst_n = 1'b1;
      cyc   = 0;
   endtask

   task automatic wait_valid(input int max_cycles);
      int w = 0;
      while (!id_valid && w < max_cycles) begin
         tick();
         w++;
      end
   endtask

   task automatic test_reset();
      lat = 1;
      do_reset();
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid: got %0b want 0", id_valid); end
      checks++; if (queue_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", queue_count); end
      checks++; if (id_pc !== 32'h0 || id_pc_plus4 !== 32'h0 || id_instr !== 32'h0) begin errors++; $display("FAIL reset_head: pc=%h pc4=%h instr=%h want 0", id_pc, id_pc_plus4, id_instr); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b want 0", imem_req); end
      release_reset();
      #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL first_req: req=%0b addr=%h want 1/00000100", imem_req, imem_addr); end
   endtask

   task automatic test_free_run();
      logic [31:0] exp_pc;
      lat = 1;
      do_reset();
      id_ready = 1'b1;
      release_reset();
      tick();
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL free_cycle1_valid: got %0b want 0", id_valid); end
      tick();
      exp_pc = 32'h100;
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (id_valid !== 1'b1 || id_pc !== exp_pc || id_instr !== ~exp_pc || id_pc_plus4 !== exp_pc + 32'd4) begin
            errors++;
            $display("FAIL free_run[%0d]: valid=%0b pc=%h instr=%h pc4=%h want pc=%h", k, id_valid, id_pc, id_instr, id_pc_plus4, exp_pc);
         end
         tick();
         exp_pc = exp_pc + 32'd4;
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] exp_pc;
      lat = 1;
      do_reset();
      release_reset();
      repeat (4) tick();
      checks++; if (queue_count !== 3'd3 || imem_req !== 1'b0) begin errors++; $display("FAIL bp_credit_stop: count=%0d req=%0b want 3/0", queue_count, imem_req); end
      repeat (16) tick();
      checks++; if (queue_count !== 3'd4) begin errors++; $display("FAIL bp_saturate: count=%0d want 4", queue_count); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_req_low: got %0b want 0", imem_req); end
      id_ready = 1'b1;
      exp_pc   = 32'h100;
      for (int k = 0; k < 12; k++) begin
         checks++;
         if (id_valid !== 1'b1 || id_pc !== exp_pc || id_instr !== ~exp_pc) begin
            errors++;
            $display("FAIL bp_drain[%0d]: valid=%0b pc=%h instr=%h want pc=%h", k, id_valid, id_pc, id_instr, exp_pc);
         end
         tick();
         exp_pc = exp_pc + 32'd4;
      end
   endtask

   task automatic test_redirect();
      logic [31:0] exp_pc;
      lat = 5;
      do_reset();
      id_ready = 1'b1;
      release_reset();
      repeat (3) tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_2000;
      tick();
      redirect_valid = 1'b0;
      #1;
      checks++; if (dut.discard_q !== 3'd3) begin errors++; $display("FAIL redir_discard_set: got %0d want 3", dut.discard_q); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h2000) begin errors++; $display("FAIL redir_new_req: req=%0b addr=%h want 1/00002000", imem_req, imem_addr); end
      wait_valid(30);
      checks++; if (cyc != 10) begin errors++; $display("FAIL redir_first_cycle: got %0d want 10", cyc); end
      checks++; if (dut.discard_q !== 3'd0) begin errors++; $display("FAIL redir_discard_clear: got %0d want 0", dut.discard_q); end
      exp_pc = 32'h2000;
      for (int k = 0; k < 4; k++) begin
         wait_valid(20);
         checks++;
         if (id_valid !== 1'b1 || id_pc !== exp_pc || id_instr !== ~exp_pc) begin
            errors++;
            $display("FAIL redir_stream[%0d]: valid=%0b pc=%h instr=%h want pc=%h", k, id_valid, id_pc, id_instr, exp_pc);
         end
         tick();
         exp_pc = exp_pc + 32'd4;
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_pc;
      lat = 5;
      do_reset();
      id_ready = 1'b1;
      release_reset();
      repeat (2) tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_3000;
      tick();
      redirect_valid = 1'b0;
      repeat (2) tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_4000;
      tick();
      redirect_valid = 1'b0;
      exp_pc = 32'h4000;
      for (int k = 0; k < 3; k++) begin
         wait_valid(30);
         checks++;
         if (id_valid !== 1'b1 || id_pc !== exp_pc || id_instr !== ~exp_pc) begin
            errors++;
            $display("FAIL b2b_stream[%0d]: valid=%0b pc=%h instr=%h want pc=%h", k, id_valid, id_pc, id_instr, exp_pc);
         end
         tick();
         exp_pc = exp_pc + 32'd4;
      end
   endtask

   task automatic test_redirect_coincident();
      lat = 1;
      do_reset();
      id_ready = 1'b1;
      release_reset();
      repeat (4) tick();
      checks++; if (id_valid !== 1'b1 || id_pc !== 32'h108) begin errors++; $display("FAIL coinc_pre: valid=%0b pc=%h want 1/00000108", id_valid, id_pc); end
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_5002;
      tick();
      redirect_valid = 1'b0;
      checks++; if (queue_count !== 3'd0 || id_valid !== 1'b0) begin errors++; $display("FAIL coinc_flush: count=%0d valid=%0b want 0/0", queue_count, id_valid); end
      checks++; if (dut.discard_q !== 3'd0) begin errors++; $display("FAIL coinc_discard: got %0d want 0", dut.discard_q); end
      #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h5000) begin errors++; $display("FAIL coinc_new_req: req=%0b addr=%h want 1/00005000", imem_req, imem_addr); end
      wait_valid(20);
      checks++;
      if (cyc != 7 || id_pc !== 32'h5000 || id_instr !== ~32'h5000) begin
         errors++;
         $display("FAIL coinc_first: cycle=%0d pc=%h instr=%h want 7/00005000", cyc, id_pc, id_instr);
      end
   endtask

   task automatic test_wrap_and_reset();
      logic [31:0] exp_pc;
      lat = 1;
      do_reset();
      id_ready = 1'b1;
      release_reset();
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFF8;
      tick();
      redirect_valid = 1'b0;
      exp_pc = 32'hFFFF_FFF8;
      for (int k = 0; k < 3; k++) begin
         wait_valid(20);
         checks++;
         if (id_valid !== 1'b1 || id_pc !== exp_pc || id_instr !== ~exp_pc || id_pc_plus4 !== exp_pc + 32'd4) begin
            errors++;
            $display("FAIL wrap[%0d]: valid=%0b pc=%h instr=%h pc4=%h want pc=%h", k, id_valid, id_pc, id_instr, id_pc_plus4, exp_pc);
         end
         tick();
         exp_pc = exp_pc + 32'd4;
      end
      rst_n = 1'b0;
      tick();
      checks++;
      if (id_valid !== 1'b0 || queue_count !== 3'd0 || id_pc !== 32'h0 || id_pc_plus4 !== 32'h0 || id_instr !== 32'h0 || imem_req !== 1'b0) begin
         errors++;
         $display("FAIL midreset: valid=%0b count=%0d pc=%h pc4=%h instr=%h req=%0b want all 0", id_valid, queue_count, id_pc, id_pc_plus4, id_instr, imem_req);
      end
      release_reset();
      #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL midreset_restart: req=%0b addr=%h want 1/00000100", imem_req, imem_addr); end
   endtask

   initial begin
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      imem_gnt       = 1'b1;
      imem_rvalid    = 1'b0;
      imem_rdata     = 32'h0;
      id_ready       = 1'b0;
      test_reset();
      test_free_run();
      test_backpressure();
      test_redirect();
      test_back_to_back();
      test_redirect_coincident();
      test_wrap_and_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
